// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder, valid/ready in and out.
// Define ENC_PSEUDO_EN to expand PUSH/POP into two-word sequences.
module instr_encoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic        err_illegal
);
`ifdef ENC_PSEUDO_EN
  localparam logic [4:0] SP = 5'd29;
  typedef enum logic [1:0] {EMPTY, LAST, FIRST} state_t;
  logic [31:0] word2, pend;
  logic        pair;
`else
  typedef enum logic [0:0] {EMPTY, LAST} state_t;
`endif
  state_t      state, state_nx;
  logic [31:0] word1;
  logic [19:0] r_base;
  logic [25:0] i_base;
  logic        illegal, fire, load;
  assign r_base = {in_rs, in_rt, in_rd, 5'd0};
  assign i_base = {in_rs, in_rt, in_imm};
  assign fire   = in_valid && in_ready;
  assign load   = fire && !illegal;
  always_comb begin
    word1   = '0;
    illegal = 1'b0;
`ifdef ENC_PSEUDO_EN
    word2 = '0;
    pair  = 1'b0;
`endif
    case (in_kind)
      5'd0:  word1 = {6'h00, r_base, 6'h04};
      5'd1:  word1 = {6'h00, r_base, 6'h06};
      5'd2:  word1 = {6'h00, r_base, 6'h07};
      5'd3:  word1 = {6'h00, in_rs, 15'd0, 6'h08};
      5'd4:  word1 = {6'h00, r_base, 6'h20};
      5'd5:  word1 = {6'h00, r_base, 6'h21};
      5'd6:  word1 = {6'h00, r_base, 6'h22};
      5'd7:  word1 = {6'h00, r_base, 6'h23};
      5'd8:  word1 = {6'h00, r_base, 6'h24};
      5'd9:  word1 = {6'h00, r_base, 6'h25};
      5'd10: word1 = {6'h00, r_base, 6'h26};
      5'd11: word1 = {6'h00, r_base, 6'h27};
      5'd12: word1 = {6'h00, r_base, 6'h28};
      5'd13: word1 = {6'h02, in_target};
      5'd14: word1 = {6'h04, i_base};
      5'd15: word1 = {6'h05, i_base};
      5'd16: word1 = {6'h06, in_rs, 5'd0, in_imm};
      5'd17: word1 = {6'h07, in_rs, 5'd0, in_imm};
      5'd18: word1 = {6'h08, i_base};
      5'd19: word1 = {6'h09, i_base};
      5'd20: word1 = {6'h0C, i_base};
      5'd21: word1 = {6'h0D, i_base};
      5'd22: word1 = {6'h0E, i_base};
      5'd23: word1 = {6'h23, i_base};
      5'd24: word1 = {6'h2B, i_base};
      5'd25: word1 = {6'h0A, i_base};
      5'd28: word1 = '0;
`ifdef ENC_PSEUDO_EN
      5'd26: begin
        word1 = 32'h23BDFFFC;
        word2 = {6'h2B, SP, in_rt, 16'h0000};
        pair  = 1'b1;
      end
      5'd27: begin
        word1 = {6'h23, SP, in_rt, 16'h0000};
        word2 = 32'h23BD0004;
        pair  = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
`ifdef ENC_PSEUDO_EN
    if (load) state_nx = pair ? FIRST : LAST;
    else if (out_ready) state_nx = (state == FIRST) ? LAST : EMPTY;
`else
    if (load) state_nx = LAST;
    else if (out_ready) state_nx = EMPTY;
`endif
  end
  always_comb begin
    out_valid = state != EMPTY;
    in_ready  = state == EMPTY || (state == LAST && out_ready);
  end
`ifdef ENC_PSEUDO_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_word    <= '0;
      out_last    <= 1'b0;
      pend        <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= fire && illegal;
      if (load) begin
        out_word <= word1;
        out_last <= !pair;
        pend     <= word2;
      end else if (state == FIRST && out_ready) begin
        out_word <= pend;
        out_last <= 1'b1;
      end
    end
`else
  assign out_last = 1'b1;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_word    <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= fire && illegal;
      if (load) out_word <= word1;
    end
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed table, pair/stall/reset sequences, and a
// randomized run checked against a word-queue model of the encoder.
module tb_instr_encoder;
  logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, err_illegal;
  logic [4:0]  in_kind = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic [31:0] out_word;
  int vectors = 0, miscompares = 0;
`ifdef ENC_PSEUDO_EN
  localparam bit PSEUDO = 1'b1;
`else
  localparam bit PSEUDO = 1'b0;
`endif
  typedef struct {
    logic [4:0]  kind, rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] word;
  } vec_t;
  vec_t tbl [12];
  logic [5:0] r_fn [13] = '{6'h04, 6'h06, 6'h07, 6'h08, 6'h20, 6'h21, 6'h22,
                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h28};
  logic [5:0] i_op [12] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C,
                            6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h0A};
  logic [32:0] q [$];
  bit exp_err, fi, fo;
  always #5 clock = ~clock;
  instr_encoder dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
    .err_illegal(err_illegal)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set(input logic [4:0] k, rs, rt, rd, input logic [15:0] imm, input logic [25:0] tg);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // Reference encoding from the field layout; n = number of words, 0 = illegal.
  function automatic void encode(input logic [4:0] k, rs, rt, rd, input logic [15:0] imm,
                                 input logic [25:0] tg, output int n, output logic [31:0] w1, w2);
    logic [31:0] s, t, d;
    s = 32'(rs) << 21; t = 32'(rt) << 16; d = 32'(rd) << 11;
    n = 1; w1 = '0; w2 = '0;
    if (k <= 12) w1 = s | ((k == 3) ? 32'd0 : (t | d)) | 32'(r_fn[int'(k)]);
    else if (k == 13) w1 = (32'd2 << 26) | 32'(tg);
    else if (k <= 25) w1 = (32'(i_op[int'(k) - 14]) << 26) | s | ((k == 16 || k == 17) ? 32'd0 : t) | 32'(imm);
    else if (k == 28) w1 = '0;
    else if (PSEUDO && k == 26) begin
      n = 2; w1 = 32'h23BDFFFC; w2 = (32'h2B << 26) | (32'd29 << 21) | t;
    end else if (PSEUDO && k == 27) begin
      n = 2; w1 = (32'h23 << 26) | (32'd29 << 21) | t; w2 = 32'h23BD0004;
    end else n = 0;
  endfunction
  initial begin
    int n;
    logic [31:0] w1, w2;
    tbl = '{
      '{5'd4,  5'd1,  5'd2, 5'd3,  16'h0000, 26'h0,       32'h00221820},
      '{5'd18, 5'd0,  5'd5, 5'd9,  16'h0010, 26'h3,       32'h20050010},
      '{5'd13, 5'd7,  5'd7, 5'd7,  16'h1234, 26'h40,      32'h08000040},
      '{5'd14, 5'd1,  5'd2, 5'd0,  16'hFFFF, 26'h0,       32'h1022FFFF},
      '{5'd16, 5'd4,  5'd7, 5'd3,  16'h0002, 26'h0,       32'h18800002},
      '{5'd3,  5'd31, 5'd5, 5'd6,  16'h5555, 26'h1,       32'h03E00008},
      '{5'd28, 5'd9,  5'd9, 5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h00000000},
      '{5'd24, 5'd29, 5'd8, 5'd0,  16'h0004, 26'h0,       32'hAFA80004},
      '{5'd25, 5'd1,  5'd2, 5'd31, 16'h0003, 26'h0,       32'h28220003},
      '{5'd11, 5'd3,  5'd4, 5'd5,  16'h0007, 26'h0,       32'h00642827},
      '{5'd13, 5'd0,  5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF},
      '{5'd12, 5'd0,  5'd0, 5'd1,  16'h0000, 26'h0,       32'h00000828}
    };
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_last", out_last, PSEUDO ? 0 : 1);
    chk("rst_err", err_illegal, 0);
    tick();
    reset = 1'b0;
    chk("idle_ready", in_ready, 1);
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      set(tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tg);
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_word", i), out_word, tbl[i].word);
      chk($sformatf("vec%0d_last", i), out_last, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    set(5'd30, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1);
    in_valid = 1'b1;
    tick();
    chk("ill30_err", err_illegal, 1);
    chk("ill30_valid", out_valid, 0);
    in_kind = 5'd31;
    tick();
    chk("ill31_err", err_illegal, 1);
    chk("ill31_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk("ill_err_clear", err_illegal, 0);
`ifdef ENC_PSEUDO_EN
    out_ready = 1'b0;
    set(5'd26, 5'd3, 5'd8, 5'd4, 16'h1234, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("push_stall_word", out_word, 32'h23BDFFFC);
      chk("push_stall_last", out_last, 0);
      chk("push_stall_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("push_first_ready", in_ready, 0);
    tick();
    chk("push_w2", out_word, 32'hAFA80000);
    chk("push_w2_last", out_last, 1);
    tick();
    chk("push_done", out_valid, 0);
    set(5'd27, 5'd0, 5'd8, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pop_w1", out_word, 32'h8FA80000);
    chk("pop_w1_last", out_last, 0);
    tick();
    chk("pop_w2", out_word, 32'h23BD0004);
    chk("pop_w2_last", out_last, 1);
    tick();
    chk("pop_done", out_valid, 0);
    out_ready = 1'b0;
    set(5'd26, 5'd0, 5'd8, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_pair_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_word", out_word, 0);
    #1 reset = 1'b0;
    set(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_word", out_word, 32'h00221820);
    chk("post_rst_last", out_last, 1);
    tick();
    chk("no_stale_w2", out_valid, 0);
`else
    set(5'd26, 5'd0, 5'd8, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("push_off_err", err_illegal, 1);
    chk("push_off_valid", out_valid, 0);
    tick();
    chk("push_off_clear", err_illegal, 0);
`endif
    exp_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      set(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      @(negedge clock);
      fo = q.size() > 0 && out_ready;
      fi = in_valid && (q.size() == 0 || (q.size() == 1 && out_ready));
      chk("rnd_valid", out_valid, q.size() > 0);
      chk("rnd_ready", in_ready, fi || !in_valid ? (q.size() == 0 || (q.size() == 1 && out_ready)) : 0);
      chk("rnd_err", err_illegal, exp_err);
      if (q.size() > 0) begin
        chk("rnd_word", out_word, q[0][31:0]);
        chk("rnd_last", out_last, q[0][32]);
      end
      tick();
      if (fo) void'(q.pop_front());
      exp_err = 1'b0;
      if (fi) begin
        encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target, n, w1, w2);
        if (n == 0) exp_err = 1'b1;
        else if (n == 1) q.push_back({1'b1, w1});
        else begin
          q.push_back({1'b0, w1});
          q.push_back({1'b1, w2});
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
